exc_collect_pipe: RTL and testbench

- Exception-tracking pipeline that sits directly upstream of the CP0 unit and produces its pre_pc / pre_badvaddr / pre_excCode / pre_is_exc / pre_is_in_ds / pre_is_eret inputs.
- Carries one exception record per instruction through the D, E and M slots, merging new causes as the instruction advances.
- Keeps the highest-priority cause in each record and presents the M-slot record to CP0.
- Flushes all slots when CP0 raises exc_occur.

---
 rtl/exc_collect_pipe_pkg.sv | 52 +++++
 rtl/exc_collect_pipe_if.sv | 62 ++++++
 rtl/exc_collect_pipe_align.sv | 22 ++
 rtl/exc_collect_pipe.sv | 121 ++++++++++++
 tb/tb_exc_collect_pipe.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_collect_pipe_pkg.sv
// Shared types for the exception-collect pipe.
// Optional trap cause enabled by EXC_COLLECT_TRAP_EN.
package exc_collect_pipe_pkg;

  localparam int ADDR_W = 32;
  localparam int EXC_W  = 5;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;
  localparam logic [EXC_W-1:0] EXC_TR   = 5'd13;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'h1f;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              in_ds;
    logic              exc;
    logic [EXC_W-1:0]  code;
    logic [ADDR_W-1:0] badvaddr;
    logic              eret;
  } slot_t;

  localparam slot_t SLOT_RST = '{
    valid:    1'b0,
    pc:       '0,
    in_ds:    1'b0,
    exc:      1'b0,
    code:     EXC_NONE,
    badvaddr: '0,
    eret:     1'b0
  };

  // Flush drops the record but leaves its payload in place.
  function automatic slot_t slot_kill(slot_t s);
    slot_t r;
    r       = s;
    r.valid = 1'b0;
    r.exc   = 1'b0;
    r.eret  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/exc_collect_pipe_if.sv
// Pipeline-side and CP0-side signals of the exception-collect pipe.
// ex_trap exists only with EXC_COLLECT_TRAP_EN.
interface exc_collect_pipe_if #(
  parameter int ADDR_W = exc_collect_pipe_pkg::ADDR_W,
  parameter int EXC_W  = exc_collect_pipe_pkg::EXC_W
) ();

  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic              if_is_in_ds;
  logic              id_ri;
  logic              id_sys;
  logic              id_bp;
  logic              id_eret;
  logic              ex_ov;
`ifdef EXC_COLLECT_TRAP_EN
  logic              ex_trap;
`endif
  logic              mem_ld;
  logic              mem_st;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic              stall;
  logic              exc_occur;

  logic [ADDR_W-1:0] pre_pc;
  logic [ADDR_W-1:0] pre_badvaddr;
  logic [EXC_W-1:0]  pre_excCode;
  logic              pre_is_exc;
  logic              pre_is_in_ds;
  logic              pre_is_eret;
  logic              mem_kill;

  modport master (
`ifdef EXC_COLLECT_TRAP_EN
    output ex_trap,
`endif
    output if_valid, if_pc, if_is_in_ds,
    output id_ri, id_sys, id_bp, id_eret,
    output ex_ov,
    output mem_ld, mem_st, mem_addr, mem_size,
    output stall, exc_occur,
    input  pre_pc, pre_badvaddr, pre_excCode,
    input  pre_is_exc, pre_is_in_ds, pre_is_eret,
    input  mem_kill
  );

  modport slave (
`ifdef EXC_COLLECT_TRAP_EN
    input  ex_trap,
`endif
    input  if_valid, if_pc, if_is_in_ds,
    input  id_ri, id_sys, id_bp, id_eret,
    input  ex_ov,
    input  mem_ld, mem_st, mem_addr, mem_size,
    input  stall, exc_occur,
    output pre_pc, pre_badvaddr, pre_excCode,
    output pre_is_exc, pre_is_in_ds, pre_is_eret,
    output mem_kill
  );

endinterface

// File: rtl/exc_collect_pipe_align.sv
// Address-alignment cause detect, shared by fetch and data checks.
// Independent of EXC_COLLECT_TRAP_EN.
module exc_align_check
  import exc_collect_pipe_pkg::*;
(
  input  logic [1:0]       addr_lo_i,
  input  logic [1:0]       size_i,
  input  logic             ld_i,
  input  logic             st_i,
  output logic             exc_o,
  output logic [EXC_W-1:0] code_o
);

  logic mis;

  assign mis = (size_i == SZ_HALF && addr_lo_i[0]) ||
               (size_i == SZ_WORD && addr_lo_i != 2'b00);

  assign exc_o  = mis & (ld_i | st_i);
  assign code_o = ld_i ? EXC_ADEL : EXC_ADES;

endmodule

// File: rtl/exc_collect_pipe.sv
// D/E/M exception-record pipe feeding CP0 pre_* inputs.
// EXC_COLLECT_TRAP_EN adds the Tr cause in the E slot.
module exc_collect_pipe
  import exc_collect_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  exc_collect_pipe_if.slave bus
);

  slot_t d_q, e_q, m_q;
  slot_t d_d, e_d, m_d;
  slot_t m_v;

  logic             if_exc;
  logic [EXC_W-1:0] if_code;
  logic             mem_exc;
  logic [EXC_W-1:0] mem_code;

  exc_align_check u_if_chk (
    .addr_lo_i (bus.if_pc[1:0]),
    .size_i    (SZ_WORD),
    .ld_i      (1'b1),
    .st_i      (1'b0),
    .exc_o     (if_exc),
    .code_o    (if_code)
  );

  exc_align_check u_mem_chk (
    .addr_lo_i (bus.mem_addr[1:0]),
    .size_i    (bus.mem_size),
    .ld_i      (bus.mem_ld),
    .st_i      (bus.mem_st),
    .exc_o     (mem_exc),
    .code_o    (mem_code)
  );

  always_comb begin
    d_d       = SLOT_RST;
    d_d.valid = bus.if_valid;
    if (bus.if_valid) begin
      d_d.pc    = bus.if_pc;
      d_d.in_ds = bus.if_is_in_ds;
      d_d.exc   = if_exc;
      if (if_exc) begin
        d_d.code     = if_code;
        d_d.badvaddr = bus.if_pc;
      end
    end
  end

  // ERET marks exc so later stages leave the record alone.
  always_comb begin
    e_d = d_q;
    if (d_q.valid && !d_q.exc) begin
      if (bus.id_ri) begin
        e_d.exc  = 1'b1;
        e_d.code = EXC_RI;
      end else if (bus.id_sys) begin
        e_d.exc  = 1'b1;
        e_d.code = EXC_SYS;
      end else if (bus.id_bp) begin
        e_d.exc  = 1'b1;
        e_d.code = EXC_BP;
      end else if (bus.id_eret) begin
        e_d.exc  = 1'b1;
        e_d.eret = 1'b1;
      end
    end
  end

  always_comb begin
    m_d = e_q;
    if (e_q.valid && !e_q.exc) begin
      if (bus.ex_ov) begin
        m_d.exc  = 1'b1;
        m_d.code = EXC_OV;
      end
`ifdef EXC_COLLECT_TRAP_EN
      else if (bus.ex_trap) begin
        m_d.exc  = 1'b1;
        m_d.code = EXC_TR;
      end
`endif
    end
  end

  always_comb begin
    m_v = m_q;
    if (m_q.valid && !m_q.exc && mem_exc) begin
      m_v.exc      = 1'b1;
      m_v.code     = mem_code;
      m_v.badvaddr = bus.mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q <= SLOT_RST;
      e_q <= SLOT_RST;
      m_q <= SLOT_RST;
    end else if (bus.exc_occur) begin
      d_q <= slot_kill(d_q);
      e_q <= slot_kill(e_q);
      m_q <= slot_kill(m_q);
    end else if (!bus.stall) begin
      d_q <= d_d;
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign bus.pre_pc       = m_v.pc;
  assign bus.pre_badvaddr = m_v.badvaddr;
  assign bus.pre_excCode  = m_v.code;
  assign bus.pre_is_exc   = m_v.valid & m_v.exc;
  assign bus.pre_is_in_ds = m_v.in_ds;
  assign bus.pre_is_eret  = m_v.eret;
  assign bus.mem_kill     = bus.pre_is_exc;

endmodule

// File: tb/tb_exc_collect_pipe.sv
// Directed plus random checks of exc_collect_pipe against a cause model.
// Trap stimulus is included when EXC_COLLECT_TRAP_EN is defined.
module tb_exc_collect_pipe;
  import exc_collect_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_collect_pipe_if bus ();

  exc_collect_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          ds;
    bit          ri, sys, bp, eret, ov, tr;
  } ins_t;

  typedef struct {
    bit          exc;
    logic [4:0]  code;
    logic [31:0] bva;
    bit          eret;
  } exp_t;

  ins_t pd, pe, pm;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string tag, string fld,
                     logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h",
             tag, fld, obs, exp);
    end
  endtask

  // Causes listed from earliest detected to latest.
  function automatic exp_t resolve(ins_t i);
    exp_t r;
    bit   mis;
    r.exc  = 0;
    r.code = EXC_NONE;
    r.bva  = '0;
    r.eret = 0;
    mis = (bus.mem_addr % (32'd1 << bus.mem_size)) != 0;
    if (i.pc % 4 != 0) begin
      r.exc = 1; r.code = 5'd4; r.bva = i.pc;
    end else if (i.ri) begin
      r.exc = 1; r.code = 5'd10;
    end else if (i.sys) begin
      r.exc = 1; r.code = 5'd8;
    end else if (i.bp) begin
      r.exc = 1; r.code = 5'd9;
    end else if (i.eret) begin
      r.exc = 1; r.eret = 1;
    end else if (i.ov) begin
      r.exc = 1; r.code = 5'd12;
    end else if (i.tr) begin
      r.exc = 1; r.code = 5'd13;
    end else if (mis && (bus.mem_ld || bus.mem_st)) begin
      r.exc  = 1;
      r.code = bus.mem_ld ? 5'd4 : 5'd5;
      r.bva  = bus.mem_addr;
    end
    return r;
  endfunction

  task automatic check_out(string tag);
    exp_t x;
    if (pm.v) begin
      x = resolve(pm);
      chk(tag, "pc",   bus.pre_pc,       pm.pc);
      chk(tag, "ds",   bus.pre_is_in_ds, pm.ds);
      chk(tag, "exc",  bus.pre_is_exc,   x.exc);
      chk(tag, "code", bus.pre_excCode,  x.code);
      chk(tag, "bva",  bus.pre_badvaddr, x.bva);
      chk(tag, "eret", bus.pre_is_eret,  x.eret);
      chk(tag, "kill", bus.mem_kill,     x.exc);
    end else begin
      chk(tag, "exc",  bus.pre_is_exc,  0);
      chk(tag, "eret", bus.pre_is_eret, 0);
      chk(tag, "kill", bus.mem_kill,    0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      pd = '{default: 0};
      pe = '{default: 0};
      pm = '{default: 0};
    end else if (bus.exc_occur) begin
      pd.v = 0;
      pe.v = 0;
      pm.v = 0;
    end else if (!bus.stall) begin
      pm    = pe;
      pm.ov = pe.v && bus.ex_ov;
`ifdef EXC_COLLECT_TRAP_EN
      pm.tr = pe.v && bus.ex_trap;
`endif
      pe      = pd;
      pe.ri   = pd.v && bus.id_ri;
      pe.sys  = pd.v && bus.id_sys;
      pe.bp   = pd.v && bus.id_bp;
      pe.eret = pd.v && bus.id_eret;
      pd      = '{default: 0};
      pd.v    = bus.if_valid;
      pd.pc   = bus.if_pc;
      pd.ds   = bus.if_is_in_ds;
    end
    #1;
  endtask

  task automatic step(string tag);
    @(negedge clk);
    check_out(tag);
    tick();
  endtask

  task automatic idle();
    bus.if_valid    = 0;
    bus.if_pc       = '0;
    bus.if_is_in_ds = 0;
    bus.id_ri       = 0;
    bus.id_sys      = 0;
    bus.id_bp       = 0;
    bus.id_eret     = 0;
    bus.ex_ov       = 0;
`ifdef EXC_COLLECT_TRAP_EN
    bus.ex_trap     = 0;
`endif
    bus.mem_ld      = 0;
    bus.mem_st      = 0;
    bus.mem_addr    = '0;
    bus.mem_size    = SZ_WORD;
    bus.stall       = 0;
    bus.exc_occur   = 0;
  endtask

  task automatic fetch(logic [31:0] pc);
    idle();
    bus.if_valid = 1;
    bus.if_pc    = pc;
    step("fetch");
    idle();
  endtask

  task automatic chk_reset(string tag);
    chk(tag, "pc",   bus.pre_pc,       0);
    chk(tag, "bva",  bus.pre_badvaddr, 0);
    chk(tag, "code", bus.pre_excCode,  32'h1f);
    chk(tag, "exc",  bus.pre_is_exc,   0);
    chk(tag, "ds",   bus.pre_is_in_ds, 0);
    chk(tag, "eret", bus.pre_is_eret,  0);
    chk(tag, "kill", bus.mem_kill,     0);
  endtask

  initial begin
    pd = '{default: 0};
    pe = '{default: 0};
    pm = '{default: 0};
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
    chk_reset("rst");

    fetch(32'hBFC0_0002);
    step("adel1");
    step("adel2");
    chk("adel", "exc",  bus.pre_is_exc,   1);
    chk("adel", "code", bus.pre_excCode,  4);
    chk("adel", "bva",  bus.pre_badvaddr, 32'hBFC0_0002);
    chk("adel", "kill", bus.mem_kill,     1);
    step("adel3");

    fetch(32'h8000_0000);
    step("st1");
    step("st2");
    bus.mem_st   = 1;
    bus.mem_size = SZ_WORD;
    bus.mem_addr = 32'h8000_0006;
    #1;
    chk("ades", "code", bus.pre_excCode,  5);
    chk("ades", "bva",  bus.pre_badvaddr, 32'h8000_0006);
    chk("ades", "kill", bus.mem_kill,     1);
    check_out("ades");
    bus.mem_size = SZ_BYTE;
    #1;
    chk("sb", "exc", bus.pre_is_exc, 0);
    step("sb");
    idle();

    fetch(32'h8000_0010);
    bus.id_ri = 1;
    step("ri_d");
    idle();
    bus.ex_ov = 1;
    step("ri_e");
    idle();
    chk("ri", "code", bus.pre_excCode, 10);
    chk("ri", "exc",  bus.pre_is_exc,  1);
    step("ri_m");

    fetch(32'h8000_0020);
    bus.id_eret = 1;
    step("eret_d");
    idle();
    step("eret_e");
    chk("eret", "eret", bus.pre_is_eret, 1);
    chk("eret", "exc",  bus.pre_is_exc,  1);
    chk("eret", "code", bus.pre_excCode, 32'h1f);
    step("eret_m");

    fetch(32'h8000_0031);
    step("stl1");
    step("stl2");
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk("stall", "code", bus.pre_excCode,  4);
      chk("stall", "bva",  bus.pre_badvaddr, 32'h8000_0031);
      step("stall");
    end
    bus.exc_occur = 1;
    step("flush");
    bus.exc_occur = 0;
    #1;
    chk("flush", "exc",  bus.pre_is_exc, 0);
    chk("flush", "kill", bus.mem_kill,   0);
    step("flush_hold");
    idle();

    fetch(32'h8000_0041);
    fetch(32'h8000_0042);
    fetch(32'h8000_0043);
    chk("full", "exc", bus.pre_is_exc, 1);
    reset = 0;
    step("rst_mid");
    reset = 1;
    chk_reset("rst_mid");
    step("rst_mid_a");

    for (int c = 0; c < 400; c++) begin
      int r;
      reset           = ($urandom_range(99) != 0);
      bus.stall       = ($urandom_range(4) == 0);
      bus.exc_occur   = ($urandom_range(19) == 0);
      bus.if_valid    = ($urandom_range(3) != 0);
      bus.if_pc       = $urandom;
      if ($urandom_range(3) != 0)
        bus.if_pc[1:0] = 2'b00;
      bus.if_is_in_ds = $urandom_range(1);
      bus.id_ri       = ($urandom_range(7) == 0);
      bus.id_sys      = ($urandom_range(7) == 0);
      bus.id_bp       = ($urandom_range(7) == 0);
      bus.id_eret     = ($urandom_range(7) == 0);
      bus.ex_ov       = ($urandom_range(5) == 0);
`ifdef EXC_COLLECT_TRAP_EN
      bus.ex_trap     = ($urandom_range(5) == 0);
`endif
      r               = $urandom_range(2);
      bus.mem_ld      = (r == 1);
      bus.mem_st      = (r == 2);
      bus.mem_addr    = $urandom;
      bus.mem_size    = 2'($urandom_range(2));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
